// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access stage: datapath width, FSM state enum,
// RV32 load/store funct3 encodings, the decoded control record handed
// down the pipe, and the default wait timeout.
package mem_access_stage_pkg;

  localparam int XLEN                = 32;
  localparam int MEM_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_REQ,
    MEM_WAIT,
    MEM_DONE
  } MEM_state_t;

  // funct3 encodings; loads and stores share the size field in [1:0]
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // mem: instruction touches memory; iop: 1 = store; fcs_opcode: funct3
  typedef struct packed {
    logic       mem;
    logic       iop;
    logic [2:0] fcs_opcode;
    logic       rd_we;
    logic [4:0] rd;
  } control_s;

  function automatic control_s control_s_default();
    control_s c;
    c = '0;
    return c;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/grant/response bus.
//   master (pipeline stage): drives mem_req/we/addr/be/wdata
//   slave  (memory)        : drives mem_gnt/rvalid/rdata
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_access_stage_align.sv
// mem_align_unit: combinational byte-lane steering for RV32 loads/stores.
//   is_store, funct3, addr[1:0] : access description
//   rs2   -> be, wdata          : store lane enables and replicated data
//   rdata -> load_data          : extracted, sign/zero-extended load value
//   fault                       : misaligned access or illegal funct3
// Loads report be = 0 and wdata = 0.
module mem_align_unit
  import mem_access_stage_pkg::*;
(
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            fault
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    be        = '0;
    wdata     = '0;
    load_data = '0;
    fault     = 1'b0;
    shifted   = rdata >> {addr, 3'b000};
    if (is_store) begin
      case (funct3)
        SB: begin
          be    = 4'b0001 << addr;
          wdata = {4{rs2[7:0]}};
        end
        SH: begin
          be    = 4'b0011 << addr;
          wdata = {2{rs2[15:0]}};
          fault = addr[0];
        end
        SW: begin
          be    = 4'b1111;
          wdata = rs2;
          fault = |addr;
        end
        default: fault = 1'b1;
      endcase
    end else begin
      case (funct3)
        LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
        LBU: load_data = {24'b0, shifted[7:0]};
        LH: begin
          load_data = {{16{shifted[15]}}, shifted[15:0]};
          fault     = addr[0];
        end
        LHU: begin
          load_data = {16'b0, shifted[15:0]};
          fault     = addr[0];
        end
        // an aligned word has a zero shift, so shifted == rdata
        LW: begin
          load_data = shifted;
          fault     = |addr;
        end
        default: fault = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline stage after execute. Issues loads/stores on a
// single-port data memory (req/gnt, then rvalid for loads), passes non-mem
// results through, and emits a one-cycle o_done with o_rd_data/o_fault.
//   i_clk, i_reset_n        : clock, async active-low reset
//   i_valid / o_ready       : upstream handshake (ready only in MEM_IDLE)
//   i_control_signal        : decoded control (mem, iop=store, funct3)
//   i_alu_result, i_rs2     : effective address / pass-through, store data
//   mem                     : data-memory bus (master side)
//   o_control_signal        : control forwarded to writeback
//   o_rd_data, o_done, o_fault : writeback result
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  control_s            i_control_signal,
  input  logic [XLEN-1:0]     i_alu_result,
  input  logic [XLEN-1:0]     i_rs2,
  mem_access_stage_if.master  mem,
  output control_s            o_control_signal,
  output logic [XLEN-1:0]     o_rd_data,
  output logic                o_done,
  output logic                o_fault
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  MEM_state_t      state;
  control_s        ctrl_q;
  logic [1:0]      addr_lo_q;
  logic [7:0]      wait_cnt;

  logic            au_is_store;
  logic [2:0]      au_funct3;
  logic [1:0]      au_addr;
  logic [3:0]      au_be;
  logic [XLEN-1:0] au_wdata;
  logic [XLEN-1:0] au_load_data;
  logic            au_fault;

  // One align unit: in IDLE it checks the incoming op (fault, be, wdata);
  // afterwards it sees the registered op so WAIT can extract load data.
  always_comb begin
    au_is_store = ctrl_q.iop;
    au_funct3   = ctrl_q.fcs_opcode;
    au_addr     = addr_lo_q;
    if (state == MEM_IDLE) begin
      au_is_store = i_control_signal.iop;
      au_funct3   = i_control_signal.fcs_opcode;
      au_addr     = i_alu_result[1:0];
    end
  end

  mem_align_unit u_align (
    .is_store  (au_is_store),
    .funct3    (au_funct3),
    .addr      (au_addr),
    .rs2       (i_rs2),
    .rdata     (mem.mem_rdata),
    .be        (au_be),
    .wdata     (au_wdata),
    .load_data (au_load_data),
    .fault     (au_fault)
  );

  assign o_control_signal = ctrl_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= MEM_IDLE;
      o_ready       <= 1'b1;
      ctrl_q        <= control_s_default();
      addr_lo_q     <= '0;
      wait_cnt      <= '0;
      o_rd_data     <= '0;
      o_done        <= 1'b0;
      o_fault       <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= '0;
      mem.mem_wdata <= '0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (i_valid) begin
            ctrl_q    <= i_control_signal;
            addr_lo_q <= i_alu_result[1:0];
            o_ready   <= 1'b0;
            if (!i_control_signal.mem) begin
              state     <= MEM_DONE;
              o_done    <= 1'b1;
              o_fault   <= 1'b0;
              o_rd_data <= i_alu_result;
            end else if (au_fault) begin
              // rejected before any bus activity
              state     <= MEM_DONE;
              o_done    <= 1'b1;
              o_fault   <= 1'b1;
              o_rd_data <= '0;
            end else begin
              state         <= MEM_REQ;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= i_control_signal.iop;
              mem.mem_addr  <= {i_alu_result[XLEN-1:2], 2'b00};
              mem.mem_be    <= au_be;
              mem.mem_wdata <= au_wdata;
            end
          end
        end
        MEM_REQ: begin
          if (mem.mem_gnt) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= '0;
            mem.mem_wdata <= '0;
            if (ctrl_q.iop) begin
              // posted write: nothing comes back
              state     <= MEM_DONE;
              o_done    <= 1'b1;
              o_fault   <= 1'b0;
              o_rd_data <= '0;
            end else begin
              state    <= MEM_WAIT;
              wait_cnt <= '0;
            end
          end
        end
        MEM_WAIT: begin
          // data arriving on the last allowed cycle still counts
          if (mem.mem_rvalid) begin
            state     <= MEM_DONE;
            o_done    <= 1'b1;
            o_fault   <= 1'b0;
            o_rd_data <= au_load_data;
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= MEM_DONE;
            o_done    <= 1'b1;
            o_fault   <= 1'b1;
            o_rd_data <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        MEM_DONE: begin
          state   <= MEM_IDLE;
          o_done  <= 1'b0;
          o_fault <= 1'b0;
          o_ready <= 1'b1;
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, random ops checked
// against an arithmetic reference model, and hand sequences for reset
// during a request and i_valid arriving while o_done is up.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic            i_clk = 1'b0;
  logic            i_reset_n;
  logic            i_valid;
  logic            o_ready;
  control_s        i_control_signal;
  logic [31:0]     i_alu_result;
  logic [31:0]     i_rs2;
  control_s        o_control_signal;
  logic [31:0]     o_rd_data;
  logic            o_done;
  logic            o_fault;

  mem_access_stage_if mif ();

  mem_access_stage dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_valid          (i_valid),
    .o_ready          (o_ready),
    .i_control_signal (i_control_signal),
    .i_alu_result     (i_alu_result),
    .i_rs2            (i_rs2),
    .mem              (mif),
    .o_control_signal (o_control_signal),
    .o_rd_data        (o_rd_data),
    .o_done           (o_done),
    .o_fault          (o_fault)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        fault;
    logic [31:0] rd;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          lat;
    logic        req;
  } exp_t;

  typedef struct {
    logic        mem;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          gd;
    int          rv;
    exp_t        e;
  } vec_t;

  typedef struct {
    int          lat;
    logic        fault;
    logic [31:0] rd;
    control_s    ctrl;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        unstable;
    logic        ready_at_done;
  } obs_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Reference: sizes, offsets and sign handling done with plain arithmetic.
  function automatic exp_t model(logic mem, logic st, logic [2:0] f3, logic [31:0] a,
                                 logic [31:0] rs2, logic [31:0] rdata, int gd, int rv);
    exp_t   e;
    int     off, nb;
    longint v;
    bit     illegal;
    e = '{fault: 1'b0, rd: 32'h0, be: 4'h0, wdata: 32'h0, lat: 1, req: 1'b0};
    if (!mem) begin
      e.rd = a;
      return e;
    end
    off     = int'(a[1:0]);
    nb      = 1 << f3[1:0];
    illegal = st ? (f3 > 3'd2) : (f3[1:0] == 2'd3 || (f3[2] && nb == 4));
    if (illegal || (off % nb) != 0) begin
      e.fault = 1'b1;
      return e;
    end
    e.req = 1'b1;
    if (st) begin
      for (int i = 0; i < 4; i++) e.be[i] = (i >= off && i < off + nb);
      e.wdata = (nb == 4) ? rs2 :
                (nb == 2) ? 32'(rs2[15:0]) * 32'h0001_0001 :
                            32'(rs2[7:0])  * 32'h0101_0101;
      e.lat = 2 + gd;
      return e;
    end
    v = longint'(rdata) >> (8 * off);
    v = v % (longint'(1) << (8 * nb));
    if (!f3[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
      v = v - (longint'(1) << (8 * nb));
    if (rv < 0) begin
      e.fault = 1'b1;
      e.lat   = 2 + gd + 255;
    end else begin
      e.rd  = v[31:0];
      e.lat = 3 + gd + rv;
    end
    return e;
  endfunction

  function automatic control_s mk_ctrl(logic mem, logic st, logic [2:0] f3);
    control_s c;
    c            = '0;
    c.mem        = mem;
    c.iop        = st;
    c.fcs_opcode = f3;
    c.rd_we      = ~st;
    c.rd         = 5'($urandom_range(1, 31));
    return c;
  endfunction

  // Called at a negedge with the stage idle. Plays the memory: grants after
  // gd request-visible cycles, returns rvalid after rv wait cycles (rv < 0:
  // never). Ends at the negedge where o_done is seen, or lat = -1.
  task automatic run_txn(input control_s c, input logic [31:0] a, input logic [31:0] rs2,
                         input int gd, input int rv, input logic [31:0] rdata, output obs_t o);
    int   req_cycles, wait_cycles;
    logic granted;
    o = '{lat: -1, fault: 1'b0, rd: 32'h0, ctrl: '0, req: 1'b0, addr: 32'h0,
          we: 1'b0, be: 4'h0, wdata: 32'h0, unstable: 1'b0, ready_at_done: 1'b0};
    req_cycles  = 0;
    wait_cycles = 0;
    granted     = 1'b0;
    i_valid          = 1'b1;
    i_control_signal = c;
    i_alu_result     = a;
    i_rs2            = rs2;
    @(negedge i_clk);
    i_valid = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      mif.mem_gnt    = 1'b0;
      mif.mem_rvalid = 1'b0;
      mif.mem_rdata  = 32'h0;
      if (o_done) begin
        o.lat           = cyc;
        o.fault         = o_fault;
        o.rd            = o_rd_data;
        o.ctrl          = o_control_signal;
        o.ready_at_done = o_ready;
        break;
      end
      if (mif.mem_req) begin
        if (!o.req) begin
          o.addr  = mif.mem_addr;
          o.we    = mif.mem_we;
          o.be    = mif.mem_be;
          o.wdata = mif.mem_wdata;
        end else if (mif.mem_addr !== o.addr || mif.mem_we !== o.we ||
                     mif.mem_be !== o.be || mif.mem_wdata !== o.wdata) begin
          o.unstable = 1'b1;
        end
        o.req = 1'b1;
        if (req_cycles == gd) begin
          mif.mem_gnt = 1'b1;
          granted     = 1'b1;
        end
        req_cycles++;
      end else if (granted && rv >= 0) begin
        if (wait_cycles == rv) begin
          mif.mem_rvalid = 1'b1;
          mif.mem_rdata  = rdata;
        end
        wait_cycles++;
      end
      @(negedge i_clk);
    end
    mif.mem_gnt    = 1'b0;
    mif.mem_rvalid = 1'b0;
  endtask

  task automatic check_txn(input string tag, input control_s c, input logic [31:0] a,
                           input exp_t e, input obs_t o);
    chk({tag, " latency"},  32'(o.lat),   32'(e.lat));
    chk({tag, " fault"},    32'(o.fault), 32'(e.fault));
    chk({tag, " rd_data"},  o.rd,         e.rd);
    chk({tag, " req_seen"}, 32'(o.req),   32'(e.req));
    if (o.lat > 0) begin
      chk({tag, " ctrl_out"},   32'(o.ctrl),          32'(c));
      chk({tag, " ready_done"}, 32'(o.ready_at_done), 32'(0));
    end
    if (e.req) begin
      chk({tag, " addr"},     o.addr,            {a[31:2], 2'b00});
      chk({tag, " we"},       32'(o.we),         32'(c.iop));
      chk({tag, " be"},       32'(o.be),         32'(e.be));
      chk({tag, " wdata"},    o.wdata,           e.wdata);
      chk({tag, " held"},     32'(o.unstable),   32'(0));
    end
    @(negedge i_clk);
    chk({tag, " ready_after"}, 32'(o_ready), 32'(1));
    chk({tag, " done_pulse"},  32'(o_done),  32'(0));
  endtask

  vec_t     tbl[16];
  obs_t     ob;
  control_s cc;

  initial begin
    i_reset_n        = 1'b0;
    i_valid          = 1'b0;
    i_control_signal = '0;
    i_alu_result     = '0;
    i_rs2            = '0;
    mif.mem_gnt      = 1'b0;
    mif.mem_rvalid   = 1'b0;
    mif.mem_rdata    = '0;

    // {mem, st, f3, addr, rs2, rdata, gnt_dly, rv_dly, {fault, rd, be, wdata, lat, req}}
    tbl[0]  = '{1'b1, 1'b0, LW,  32'h100, 32'h0,        32'hDEADBEEF, 0, 0,  '{1'b0, 32'hDEADBEEF, 4'h0, 32'h0, 3, 1'b1}};
    tbl[1]  = '{1'b1, 1'b0, LB,  32'h103, 32'h0,        32'h80FF0011, 0, 0,  '{1'b0, 32'hFFFFFF80, 4'h0, 32'h0, 3, 1'b1}};
    tbl[2]  = '{1'b1, 1'b0, LBU, 32'h103, 32'h0,        32'h80FF0011, 0, 0,  '{1'b0, 32'h00000080, 4'h0, 32'h0, 3, 1'b1}};
    tbl[3]  = '{1'b1, 1'b1, SH,  32'h202, 32'h1234ABCD, 32'h0,        3, 0,  '{1'b0, 32'h0, 4'b1100, 32'hABCDABCD, 5, 1'b1}};
    tbl[4]  = '{1'b1, 1'b0, LW,  32'h101, 32'h0,        32'h0,        0, 0,  '{1'b1, 32'h0, 4'h0, 32'h0, 1, 1'b0}};
    tbl[5]  = '{1'b0, 1'b0, 3'b000, 32'h55, 32'h0,      32'h0,        0, 0,  '{1'b0, 32'h55, 4'h0, 32'h0, 1, 1'b0}};
    tbl[6]  = '{1'b1, 1'b0, LH,  32'h102, 32'h0,        32'h80FF0011, 1, 2,  '{1'b0, 32'hFFFF80FF, 4'h0, 32'h0, 6, 1'b1}};
    tbl[7]  = '{1'b1, 1'b0, LHU, 32'h102, 32'h0,        32'h80FF0011, 0, 0,  '{1'b0, 32'h000080FF, 4'h0, 32'h0, 3, 1'b1}};
    tbl[8]  = '{1'b1, 1'b1, SB,  32'h301, 32'h000000A5, 32'h0,        0, 0,  '{1'b0, 32'h0, 4'b0010, 32'hA5A5A5A5, 2, 1'b1}};
    tbl[9]  = '{1'b1, 1'b1, SW,  32'h400, 32'hCAFEF00D, 32'h0,        0, 0,  '{1'b0, 32'h0, 4'b1111, 32'hCAFEF00D, 2, 1'b1}};
    tbl[10] = '{1'b1, 1'b0, 3'b011, 32'h0,  32'h0,      32'h0,        0, 0,  '{1'b1, 32'h0, 4'h0, 32'h0, 1, 1'b0}};
    tbl[11] = '{1'b1, 1'b1, 3'b100, 32'h0,  32'h0,      32'h0,        0, 0,  '{1'b1, 32'h0, 4'h0, 32'h0, 1, 1'b0}};
    tbl[12] = '{1'b1, 1'b1, SH,  32'h203, 32'h0,        32'h0,        0, 0,  '{1'b1, 32'h0, 4'h0, 32'h0, 1, 1'b0}};
    tbl[13] = '{1'b1, 1'b0, LW,  32'h500, 32'h0,        32'h0,        0, -1, '{1'b1, 32'h0, 4'h0, 32'h0, 257, 1'b1}};
    tbl[14] = '{1'b1, 1'b0, LW,  32'h504, 32'h0,        32'h12345678, 0, 254,'{1'b0, 32'h12345678, 4'h0, 32'h0, 257, 1'b1}};
    tbl[15] = '{1'b1, 1'b0, 3'b110, 32'h8,  32'h0,      32'h0,        0, 0,  '{1'b1, 32'h0, 4'h0, 32'h0, 1, 1'b0}};

    repeat (2) @(negedge i_clk);
    chk("rst ready",   32'(o_ready),          32'(1));
    chk("rst req",     32'(mif.mem_req),      32'(0));
    chk("rst done",    32'(o_done),           32'(0));
    chk("rst fault",   32'(o_fault),          32'(0));
    chk("rst rd_data", o_rd_data,             32'h0);
    chk("rst addr",    mif.mem_addr,          32'h0);
    chk("rst be",      32'(mif.mem_be),       32'(0));
    chk("rst ctrl",    32'(o_control_signal), 32'(control_s_default()));
    i_reset_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 16; i++) begin
      cc = mk_ctrl(tbl[i].mem, tbl[i].st, tbl[i].f3);
      run_txn(cc, tbl[i].addr, tbl[i].rs2, tbl[i].gd, tbl[i].rv, tbl[i].rdata, ob);
      check_txn($sformatf("vec%0d", i), cc, tbl[i].addr, tbl[i].e, ob);
    end

    // reset while a request is outstanding
    cc = mk_ctrl(1'b1, 1'b0, LW);
    i_valid = 1'b1; i_control_signal = cc; i_alu_result = 32'h600;
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("rreq pending", 32'(mif.mem_req), 32'(1));
    #2 i_reset_n = 1'b0;
    #1;
    chk("rreq req",   32'(mif.mem_req),      32'(0));
    chk("rreq ready", 32'(o_ready),          32'(1));
    chk("rreq state", 32'(dut.state),        32'(MEM_IDLE));
    chk("rreq ctrl",  32'(o_control_signal), 32'(control_s_default()));
    @(negedge i_clk);
    i_reset_n = 1'b1;
    mif.mem_rvalid = 1'b1; mif.mem_gnt = 1'b1; mif.mem_rdata = 32'hBADBAD00;
    @(negedge i_clk);
    mif.mem_rvalid = 1'b0; mif.mem_gnt = 1'b0;
    chk("late done",  32'(o_done),      32'(0));
    chk("late ready", 32'(o_ready),     32'(1));
    chk("late req",   32'(mif.mem_req), 32'(0));

    // i_valid while o_done is up must be dropped
    cc = mk_ctrl(1'b0, 1'b0, 3'b000);
    i_valid = 1'b1; i_control_signal = cc; i_alu_result = 32'h77;
    @(negedge i_clk);
    chk("dv done", 32'(o_done), 32'(1));
    chk("dv rd",   o_rd_data,   32'h77);
    i_alu_result = 32'h99;
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("dv done2",  32'(o_done),  32'(0));
    chk("dv ready2", 32'(o_ready), 32'(1));
    @(negedge i_clk);
    chk("dv done3",  32'(o_done),  32'(0));

    // random ops against the reference model
    for (int k = 0; k < 60; k++) begin
      logic        m, s;
      logic [2:0]  f;
      logic [31:0] a, r2, rd;
      int          g, v;
      m  = ($urandom_range(0, 4) != 0);
      s  = 1'($urandom_range(0, 1));
      f  = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      r2 = $urandom;
      rd = $urandom;
      g  = $urandom_range(0, 3);
      v  = $urandom_range(0, 3);
      cc = mk_ctrl(m, s, f);
      run_txn(cc, a, r2, g, v, rd, ob);
      check_txn($sformatf("rnd%0d", k), cc, a, model(m, s, f, a, r2, rd, g, v), ob);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of execute_stage; consumes its control_s, effective address (ALU result) and rs2 store data.
- Performs loads and stores against a single-port data memory over a request/grant/response handshake.
- Non-memory instructions pass through unchanged to writeback.
- Produces the rd write value (aligned and sign/zero-extended load data, or the ALU result), a done pulse and a fault flag.

Parameters:
- XLEN, 32, datapath width (taken from rapid_pkg; only 32 is supported).
- MEM_TIMEOUT, 255, cycles allowed in MEM_WAIT before a fault is declared (8-bit counter).

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  upstream result valid (execute o_done)
- o_ready  out  1  stage can accept (high only in MEM_IDLE)
- i_control_signal  in  control_s  decoded control (mem, iop=store, fcs_opcode=funct3)
- i_alu_result  in  XLEN  effective address, or rd value for non-mem ops
- i_rs2  in  XLEN  store data
- o_mem_req  out  1  memory request
- o_mem_we  out  1  1=store
- o_mem_addr  out  XLEN  word-aligned address {addr[31:2],2'b00}
- o_mem_be  out  4  byte enables
- o_mem_wdata  out  XLEN  lane-replicated store data
- i_mem_gnt  in  1  request accepted this cycle
- i_mem_rvalid  in  1  load data valid
- i_mem_rdata  in  XLEN  load word
- o_control_signal  out  control_s  control forwarded to writeback
- o_rd_data  out  XLEN  writeback value
- o_done  out  1  one-cycle result-valid pulse
- o_fault  out  1  misaligned, illegal funct3 or timeout; valid with o_done

Behaviour:
- Reset (async, i_reset_n=0):
  - State MEM_IDLE.
  - All outputs 0, except o_ready=1 and o_control_signal=control_s_default().
  - An in-flight request is abandoned; o_mem_req drops immediately.
  - A late i_mem_rvalid after reset is ignored.
- States: MEM_IDLE, MEM_REQ, MEM_WAIT, MEM_DONE.
- MEM_IDLE: on i_valid, register control, address and rs2.
  - If !mem: go to MEM_DONE with o_rd_data=i_alu_result.
  - If mem and faulting: go to MEM_DONE with o_fault=1; no memory request is issued.
  - Otherwise go to MEM_REQ.
- MEM_REQ:
  - o_mem_req=1; addr, we, be and wdata held stable until i_mem_gnt.
  - On gnt: a store goes to MEM_DONE (posted write); a load goes to MEM_WAIT.
- MEM_WAIT:
  - On i_mem_rvalid, register the extracted data and go to MEM_DONE.
  - Counter reaching MEM_TIMEOUT: go to MEM_DONE with o_fault=1 and o_rd_data=0.
  - rvalid in the same cycle as timeout: data wins, no fault.
- MEM_DONE: o_done=1 for exactly one cycle, o_rd_data and o_control_signal valid; then MEM_IDLE. i_valid is ignored here (o_ready=0).
- Latency from the accept edge:
  - non-mem: 1 cycle to o_done.
  - store with same-cycle gnt: 2 cycles.
  - load with gnt then rvalid next cycle: 3 cycles.
- Fault rules:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
  - Load funct3 in {011,110,111}.
  - Store funct3 >010.
- Store alignment:
  - SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=4'b0011<<addr[1:0], wdata={2{rs2[15:0]}}.
  - SW: be=4'b1111, wdata=rs2.
- Load extraction: shifted = rdata >> (8*addr[1:0]).
  - LB: sign-extend shifted[7:0].
  - LBU: zero-extend shifted[7:0].
  - LH: sign-extend shifted[15:0].
  - LHU: zero-extend shifted[15:0].
  - LW: rdata.
- For stores, o_rd_data=0 (writeback ignores it).
- i_mem_gnt outside MEM_REQ and i_mem_rvalid outside MEM_WAIT are ignored.

Decomposition:
- rapid_pkg additions:
  - MEM_state_t enum (MEM_IDLE, MEM_REQ, MEM_WAIT, MEM_DONE).
  - funct3 constants LB, LH, LW, LBU, LHU, SB, SH, SW.
  - MEM_TIMEOUT default.
- Sub-module mem_align_unit, purely combinational:
  - Inputs: funct3, addr[1:0], rs2, rdata.
  - Outputs: be, wdata, load_data, fault.
  - Unit-tested standalone.

Test Plan:
- LW, addr 0x100, gnt same cycle, rdata 0xDEADBEEF next cycle -> o_mem_addr=0x100, be=4'b0000, o_done 3 cycles after accept, o_rd_data=0xDEADBEEF, o_fault=0.
- LB addr 0x103 and LBU addr 0x103, rdata 0x80FF0011 -> 0xFFFFFF80 and 0x00000080.
- SH addr 0x202, rs2 0x1234ABCD, gnt delayed 3 cycles -> req and signals held 3 cycles, be=4'b1100, wdata=0xABCDABCD, o_done 1 cycle after gnt.
- LW addr 0x101 -> no o_mem_req, o_done with o_fault=1 one cycle after accept.
- Non-mem ADD result 0x55 -> o_done next cycle, o_rd_data=0x55, o_mem_req never asserted.
- Load with gnt but no rvalid -> o_fault=1 after 255 wait cycles; separately, i_reset_n low during MEM_REQ -> o_mem_req=0 immediately, o_ready=1, state MEM_IDLE.
